alu_ctrl_decoder: RTL and testbench

- Producer side of the ALU control interface: accepts a 32-bit MIPS-format instruction over a valid/ready handshake.
- Decodes it into the 12-bit ALU control code, rs/rt register indices and an extended immediate, then holds them stable for the ALU's latency.
- Captures the ALU result and returns it over a second valid/ready handshake.
- Sits between instruction fetch/issue and the ALU in the RISC datapath.

---
 rtl/alu_ctrl_decoder_if.sv | 29 ++
 rtl/alu_ctrl_decoder.sv | 172 +++++++++++++++++
 tb/tb_alu_ctrl_decoder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_decoder_if.sv
// Handshake and control bundle between instruction issue, the ALU control decoder and the ALU.
// The decoder drives through the master modport; issue/ALU/consumer logic uses slave.
interface alu_ctrl_decoder_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [11:0] alu_cnt;
  logic [31:0] alu_imm;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_illegal;
  logic        busy;

  modport master (
    input  instr_valid, instr, alu_out, res_ready,
    output instr_ready, alu_cnt, alu_imm, rs_addr, rt_addr,
           res_valid, res_data, res_illegal, busy
  );

  modport slave (
    output instr_valid, instr, alu_out, res_ready,
    input  instr_ready, alu_cnt, alu_imm, rs_addr, rt_addr,
           res_valid, res_data, res_illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// Decodes a MIPS instruction into ALU control, holds it for the ALU latency and returns the result.
// Optional macro ALU_DEC_LUI_EN makes op=15 (lui) legal, executed as r0 | (imm << 16).
module alu_ctrl_decoder #(
  parameter int ALU_LAT      = 1,
  parameter int MULDIV_EXTRA = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_ctrl_decoder_if.master bus
);

`ifdef ALU_DEC_LUI_EN
  localparam bit LUI_EN = 1'b1;
`else
  localparam bit LUI_EN = 1'b0;
`endif

  localparam logic [7:0] LAT_BASE = 8'(ALU_LAT);
  localparam logic [7:0] LAT_LONG = 8'(ALU_LAT + MULDIV_EXTRA);

  typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  lat_reg, lat_next;
  logic [11:0] code_reg, code_next;
  logic [31:0] imm_reg, imm_next;
  logic [4:0]  rs_reg, rs_next;
  logic [4:0]  rt_reg, rt_next;
  logic [31:0] res_reg, res_next;
  logic        illegal_reg, illegal_next;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic        dec_legal, dec_sext, dec_zext, dec_lui, dec_muldiv;
  logic [11:0] dec_code;
  logic [15:0] ext_hi;
  logic [31:0] dec_imm;

  assign op = bus.instr[31:26];
  assign fn = bus.instr[5:0];

  always_comb begin
    dec_legal  = 1'b0;
    dec_sext   = 1'b0;
    dec_zext   = 1'b0;
    dec_lui    = 1'b0;
    dec_muldiv = 1'b0;
    dec_code   = 12'd0;
    if (op == 6'd0) begin
      case (fn)
        6'd24, 6'd26, 6'd32, 6'd34, 6'd36, 6'd37: begin
          dec_legal  = 1'b1;
          dec_code   = {6'b0, fn};
          dec_muldiv = (fn == 6'd24) || (fn == 6'd26);
        end
        default: ;
      endcase
    end else begin
      case (op)
        6'd8, 6'd32, 6'd40: begin
          dec_legal = 1'b1;
          dec_sext  = 1'b1;
          dec_code  = {op, 6'b0};
        end
        6'd12, 6'd13: begin
          dec_legal = 1'b1;
          dec_zext  = 1'b1;
          dec_code  = {op, 6'b0};
        end
        6'd15: begin
          // lui reuses the ori datapath: rs forced to r0, immediate pre-shifted
          dec_legal = LUI_EN;
          dec_lui   = LUI_EN;
          dec_code  = LUI_EN ? 12'd832 : 12'd0;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_ext
      assign ext_hi[gi] = dec_sext & bus.instr[15];
    end
  endgenerate

  always_comb begin
    dec_imm = 32'd0;
    if (dec_lui)
      dec_imm = {bus.instr[15:0], 16'b0};
    else if (dec_sext || dec_zext)
      dec_imm = {ext_hi, bus.instr[15:0]};
  end

  always_comb begin
    state_next   = state_reg;
    lat_next     = lat_reg;
    code_next    = code_reg;
    imm_next     = imm_reg;
    rs_next      = rs_reg;
    rt_next      = rt_reg;
    res_next     = res_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      IDLE: begin
        if (bus.instr_valid) begin
          code_next = dec_code;
          imm_next  = dec_imm;
          rs_next   = dec_lui ? 5'd0 : bus.instr[25:21];
          rt_next   = bus.instr[20:16];
          if (dec_legal) begin
            lat_next   = dec_muldiv ? LAT_LONG : LAT_BASE;
            state_next = EXEC;
          end else begin
            res_next     = 32'd0;
            illegal_next = 1'b1;
            state_next   = RESULT;
          end
        end
      end
      EXEC: begin
        if (lat_reg == 8'd0) begin
          res_next     = bus.alu_out;
          illegal_next = 1'b0;
          state_next   = RESULT;
        end else begin
          lat_next = lat_reg - 8'd1;
        end
      end
      RESULT: begin
        if (bus.res_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      lat_reg     <= 8'd0;
      code_reg    <= 12'd0;
      imm_reg     <= 32'd0;
      rs_reg      <= 5'd0;
      rt_reg      <= 5'd0;
      res_reg     <= 32'd0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lat_reg     <= lat_next;
      code_reg    <= code_next;
      imm_reg     <= imm_next;
      rs_reg      <= rs_next;
      rt_reg      <= rt_next;
      res_reg     <= res_next;
      illegal_reg <= illegal_next;
    end
  end

  // Control code is only presented while the ALU is actually working on it
  assign bus.alu_cnt     = (state_reg == EXEC) ? code_reg : 12'd0;
  assign bus.alu_imm     = imm_reg;
  assign bus.rs_addr     = rs_reg;
  assign bus.rt_addr     = rt_reg;
  assign bus.instr_ready = (state_reg == IDLE);
  assign bus.busy        = (state_reg != IDLE);
  assign bus.res_valid   = (state_reg == RESULT);
  assign bus.res_data    = res_reg;
  assign bus.res_illegal = illegal_reg;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Bench for alu_ctrl_decoder: directed test-plan cases followed by random instructions,
// all compared against a decode/latency reference model built from the instruction rules.
module tb_alu_ctrl_decoder;
  localparam int ALU_LAT      = 1;
  localparam int MULDIV_EXTRA = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_ctrl_decoder_if bus();

  alu_ctrl_decoder #(.ALU_LAT(ALU_LAT), .MULDIV_EXTRA(MULDIV_EXTRA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        legal;
    logic [11:0] code;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    int          lat;
  } exp_t;

  // Expected decode and accept-to-res_valid latency from the instruction-set rules
  function automatic exp_t model(logic [31:0] w);
    exp_t e;
    int op = int'(w >> 26);
    int fn = int'(w % 64);
    int lo = int'(w % 65536);
    e.legal = 1'b0;
    e.code  = 12'd0;
    e.imm   = 32'd0;
    e.rs    = 5'((w >> 21) % 32);
    e.rt    = 5'((w >> 16) % 32);
    e.lat   = 1;
    if (op == 0 && fn inside {24, 26, 32, 34, 36, 37}) begin
      e.legal = 1'b1;
      e.code  = 12'(fn);
      e.lat   = ALU_LAT + 2 + ((fn == 24 || fn == 26) ? MULDIV_EXTRA : 0);
    end else if (op inside {8, 32, 40}) begin
      e.legal = 1'b1;
      e.code  = 12'(op * 64);
      e.imm   = (lo >= 32768) ? 32'(lo - 65536) : 32'(lo);
      e.lat   = ALU_LAT + 2;
    end else if (op inside {12, 13}) begin
      e.legal = 1'b1;
      e.code  = 12'(op * 64);
      e.imm   = 32'(lo);
      e.lat   = ALU_LAT + 2;
    end
`ifdef ALU_DEC_LUI_EN
    else if (op == 15) begin
      e.legal = 1'b1;
      e.code  = 12'd832;
      e.rs    = 5'd0;
      e.imm   = 32'(lo) * 32'd65536;
      e.lat   = ALU_LAT + 2;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_alu_cnt"}, 32'(bus.alu_cnt), 32'd0);
    chk({tag, "_alu_imm"}, bus.alu_imm, 32'd0);
    chk({tag, "_rs"}, 32'(bus.rs_addr), 32'd0);
    chk({tag, "_rt"}, 32'(bus.rt_addr), 32'd0);
    chk({tag, "_res_data"}, bus.res_data, 32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_res_illegal"}, 32'(bus.res_illegal), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_instr_ready"}, 32'(bus.instr_ready), 32'd1);
  endtask

  // One full transaction: accept, watch EXEC, check result, hold backpressure, hand off
  task automatic run_instr(input logic [31:0] w, input logic use_fixed,
                           input logic [31:0] fixed_val, input int hold);
    exp_t        e;
    int          lat;
    logic [31:0] last_alu;
    e = model(w);
    last_alu = 32'd0;
    chk("ready_before_accept", 32'(bus.instr_ready), 32'd1);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
    lat = 1;
    while (!bus.res_valid && lat < 300) begin
      chk("exec_alu_cnt", 32'(bus.alu_cnt), 32'(e.code));
      chk("exec_alu_imm", bus.alu_imm, e.imm);
      chk("exec_rs", 32'(bus.rs_addr), 32'(e.rs));
      chk("exec_rt", 32'(bus.rt_addr), 32'(e.rt));
      chk("exec_instr_ready", 32'(bus.instr_ready), 32'd0);
      chk("exec_busy", 32'(bus.busy), 32'd1);
      bus.alu_out = (use_fixed && lat >= 2) ? fixed_val : $urandom;
      last_alu = bus.alu_out;
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(e.lat));
    for (int h = 0; h <= hold; h++) begin
      chk("res_valid", 32'(bus.res_valid), 32'd1);
      chk("res_data", bus.res_data, e.legal ? last_alu : 32'd0);
      chk("res_illegal", 32'(bus.res_illegal), 32'(!e.legal));
      chk("result_alu_cnt", 32'(bus.alu_cnt), 32'd0);
      chk("result_instr_ready", 32'(bus.instr_ready), 32'd0);
      if (!e.legal) begin
        chk("illegal_rs", 32'(bus.rs_addr), 32'(e.rs));
        chk("illegal_rt", 32'(bus.rt_addr), 32'(e.rt));
      end
      if (h < hold) step();
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("handoff_res_valid", 32'(bus.res_valid), 32'd0);
    chk("handoff_instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("handoff_busy", 32'(bus.busy), 32'd0);
    $display("txn instr=0x%08h legal=%0d lat=%0d res_data=0x%08h hold=%0d",
             w, e.legal, lat, bus.res_data, hold);
  endtask

  initial begin
    logic [31:0] w;
    logic [5:0]  op_list [7];
    logic [5:0]  fn_list [6];
    op_list = '{6'd0, 6'd8, 6'd32, 6'd40, 6'd12, 6'd13, 6'd15};
    fn_list = '{6'd24, 6'd26, 6'd32, 6'd34, 6'd36, 6'd37};

    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    bus.alu_out     = 32'd0;
    bus.res_ready   = 1'b0;

    // Power-up reset
    rst_n = 1'b0;
    step();
    step();
    chk_idle_zero("reset");
    rst_n = 1'b1;
    step();
    chk_idle_zero("post_reset");

    // Instruction presented without valid must be ignored
    bus.instr = 32'h00221820;
    step();
    chk("ignored_busy", 32'(bus.busy), 32'd0);

    // Directed test-plan cases
    run_instr(32'h00221820, 1'b1, 32'd265, 0);
    chk("add_res_data", bus.res_data, 32'd265);
    run_instr(32'h2022FFFF, 1'b0, 32'd0, 0);
    run_instr(32'h3022FFFF, 1'b0, 32'd0, 0);
    run_instr(32'h20220140, 1'b0, 32'd0, 1);
    run_instr(32'h00220018, 1'b0, 32'd0, 0);
    run_instr(32'h3C01ABCD, 1'b0, 32'd0, 0);
    run_instr(32'h0022181A, 1'b0, 32'd0, 5);
    run_instr(32'hFC000000, 1'b0, 32'd0, 2);

    // Reset in the middle of EXEC drops the instruction
    bus.instr       = 32'h20220140;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("midexec_alu_cnt", 32'(bus.alu_cnt), 32'd512);
    rst_n = 1'b0;
    step();
    chk_idle_zero("midexec_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("dropped_res_valid", 32'(bus.res_valid), 32'd0);
    end

    // Random instructions biased toward the decodable opcodes
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        w[31:26] = op_list[$urandom_range(0, 6)];
        if (w[31:26] == 6'd0 && $urandom_range(0, 5) != 0)
          w[5:0] = fn_list[$urandom_range(0, 5)];
      end
      run_instr(w, 1'b0, 32'd0, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
